// File: rtl/ldpc_dec_core_if.sv
// Bus between the top-level LLR staging registers and ldpc_dec_core:
// eight-column load beats in, hard-decision word with valid pulse out.
interface ldpc_dec_core_if #(
    parameter int unsigned ZC              = 64,
    parameter int unsigned VWIDTH          = 8,
    parameter int unsigned DEC_OUT_LIFTING = 22,
    parameter int unsigned APP_ADDR_WIDTH  = 6
);
    logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_0;
    logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_1;
    logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_2;
    logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_3;
    logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_4;
    logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_5;
    logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_6;
    logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_7;
    logic [1:0]                    APPmsg_ini_sub_x;
    logic                          buffer_valid;
    logic                          buffer_start;
    logic                          buffer_last;
    logic [2:0]                    iLs;
    logic [2:0]                    jLs;
    logic [5:0]                    P;
    logic [APP_ADDR_WIDTH-1:0]     APP_addr_max;
    logic [APP_ADDR_WIDTH-2:0]     APP_addr_rd_max;
    logic                          buffer_ready;
    logic                          decode_valid;
    logic [2:0]                    decode_valid_cnt;
    logic [ZC*DEC_OUT_LIFTING-1:0] APPmsg_decode_out;

    modport master (
        output APPmsg_ini_subx_0, APPmsg_ini_subx_1, APPmsg_ini_subx_2, APPmsg_ini_subx_3,
               APPmsg_ini_subx_4, APPmsg_ini_subx_5, APPmsg_ini_subx_6, APPmsg_ini_subx_7,
               APPmsg_ini_sub_x, buffer_valid, buffer_start, buffer_last,
               iLs, jLs, P, APP_addr_max, APP_addr_rd_max,
        input  buffer_ready, decode_valid, decode_valid_cnt, APPmsg_decode_out
    );

    modport slave (
        input  APPmsg_ini_subx_0, APPmsg_ini_subx_1, APPmsg_ini_subx_2, APPmsg_ini_subx_3,
               APPmsg_ini_subx_4, APPmsg_ini_subx_5, APPmsg_ini_subx_6, APPmsg_ini_subx_7,
               APPmsg_ini_sub_x, buffer_valid, buffer_start, buffer_last,
               iLs, jLs, P, APP_addr_max, APP_addr_rd_max,
        output buffer_ready, decode_valid, decode_valid_cnt, APPmsg_decode_out
    );
endinterface

// File: rtl/ldpc_dec_core.sv
// LDPC decoder LLR buffer and hard-decision back end (IDLE/LOAD/PROC).
// Define LDPC_DEC_FRAME_CNT_EN to enable the decode_valid_cnt frame counter.
module ldpc_dec_core #(
    parameter int unsigned ZC              = 64,
    parameter int unsigned VWIDTH          = 8,
    parameter int unsigned DEC_OUT_LIFTING = 22,
    parameter int unsigned APP_ADDR_WIDTH  = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    ldpc_dec_core_if.slave  io_bus
);
    localparam int unsigned NGRP_COLS = 8;
    localparam int unsigned CNT_W     = APP_ADDR_WIDTH + 1;
    localparam int unsigned OUT_W     = ZC * DEC_OUT_LIFTING;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PROC} state_t;

    state_t                                r_state;
    logic [DEC_OUT_LIFTING-1:0][ZC-1:0]    r_sign;
    logic [CNT_W-1:0]                      r_cnt;
    logic                                  r_buffer_ready;
    logic                                  r_decode_valid;
    logic [OUT_W-1:0]                      r_decode_out;

    logic [ZC*VWIDTH-1:0]                  w_subx [NGRP_COLS];
    logic [NGRP_COLS-1:0][ZC-1:0]          w_grp_sign;
    logic [DEC_OUT_LIFTING-1:0]            w_col_we;
    logic                                  w_wr_en;
    logic                                  w_last_acc;
    logic                                  w_mag_unused;
    logic                                  w_in_unused;

    assign w_subx[0] = io_bus.APPmsg_ini_subx_0;
    assign w_subx[1] = io_bus.APPmsg_ini_subx_1;
    assign w_subx[2] = io_bus.APPmsg_ini_subx_2;
    assign w_subx[3] = io_bus.APPmsg_ini_subx_3;
    assign w_subx[4] = io_bus.APPmsg_ini_subx_4;
    assign w_subx[5] = io_bus.APPmsg_ini_subx_5;
    assign w_subx[6] = io_bus.APPmsg_ini_subx_6;
    assign w_subx[7] = io_bus.APPmsg_ini_subx_7;

    // Reserved inputs and buffer_start (restart keeps stored data) have no effect.
    assign w_in_unused = ^{io_bus.jLs, io_bus.P, io_bus.APP_addr_rd_max, io_bus.buffer_start};

    // Only the sign plane feeds the hard decision, so magnitudes are not retained.
    always_comb begin : p_sign_plane
        w_mag_unused = 1'b0;
        for (int k = 0; k < NGRP_COLS; k++) begin
            for (int z = 0; z < ZC; z++) begin
                w_grp_sign[k][z] = w_subx[k][z*VWIDTH + VWIDTH - 1];
                w_mag_unused     = w_mag_unused ^ (^w_subx[k][z*VWIDTH +: (VWIDTH - 1)]);
            end
        end
    end

    // Group 3 is dropped in 24-column mode; columns beyond the output set are never read.
    assign w_wr_en = (r_state != S_PROC) && io_bus.buffer_valid &&
                     !((io_bus.iLs == 3'd2) && (io_bus.APPmsg_ini_sub_x == 2'd3));

    assign w_last_acc = ((r_state == S_IDLE) && io_bus.buffer_valid && io_bus.buffer_last) ||
                        ((r_state == S_LOAD) && io_bus.buffer_last);

    always_comb begin : p_col_we
        for (int c = 0; c < DEC_OUT_LIFTING; c++) begin
            w_col_we[c] = w_wr_en && (io_bus.APPmsg_ini_sub_x == 2'(c / NGRP_COLS));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_store
        if (!rst_n) begin
            r_sign <= '0;
        end else begin
            for (int c = 0; c < DEC_OUT_LIFTING; c++) begin
                if (w_col_we[c]) begin
                    r_sign[c] <= w_grp_sign[c % NGRP_COLS];
                end
            end
        end
    end

    // Down-counter of APP_addr_max+1 places decode_valid APP_addr_max+2 edges after buffer_last.
    always_ff @(posedge clk or negedge rst_n) begin : p_fsm
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_buffer_ready <= 1'b1;
            r_decode_valid <= 1'b0;
            r_decode_out   <= '0;
        end else begin
            r_decode_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_last_acc) begin
                        r_state        <= S_PROC;
                        r_cnt          <= CNT_W'(io_bus.APP_addr_max) + CNT_W'(1);
                        r_buffer_ready <= 1'b0;
                    end else if ((r_state == S_IDLE) && io_bus.buffer_valid) begin
                        r_state <= S_LOAD;
                    end
                end
                S_PROC: begin
                    if (r_cnt == '0) begin
                        r_state        <= S_IDLE;
                        r_buffer_ready <= 1'b1;
                        r_decode_valid <= 1'b1;
                        r_decode_out   <= r_sign;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef LDPC_DEC_FRAME_CNT_EN
    logic [2:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin : p_frame_cnt
        if (!rst_n) begin
            r_frame_cnt <= 3'd0;
        end else if (r_decode_valid) begin
            r_frame_cnt <= r_frame_cnt + 3'd1;
        end
    end

    assign io_bus.decode_valid_cnt = r_frame_cnt;
`else
    assign io_bus.decode_valid_cnt = 3'd0;
`endif

    assign io_bus.buffer_ready      = r_buffer_ready;
    assign io_bus.decode_valid      = r_decode_valid;
    assign io_bus.APPmsg_decode_out = r_decode_out;
endmodule

// File: tb/tb_ldpc_dec_core.sv
// Randomized self-checking bench for ldpc_dec_core against a column-array LLR model.
`timescale 1ns/1ps
module tb_ldpc_dec_core;
    localparam int ZC    = 64;
    localparam int VW    = 8;
    localparam int DOL   = 22;
    localparam int AW    = 6;
    localparam int NCOL  = 32;
    localparam int OUTW  = ZC * DOL;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ldpc_dec_core_if #(.ZC(ZC), .VWIDTH(VW), .DEC_OUT_LIFTING(DOL), .APP_ADDR_WIDTH(AW)) bus ();

    ldpc_dec_core #(.ZC(ZC), .VWIDTH(VW), .DEC_OUT_LIFTING(DOL), .APP_ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    logic [ZC*VW-1:0] lane [8];
    assign bus.APPmsg_ini_subx_0 = lane[0];
    assign bus.APPmsg_ini_subx_1 = lane[1];
    assign bus.APPmsg_ini_subx_2 = lane[2];
    assign bus.APPmsg_ini_subx_3 = lane[3];
    assign bus.APPmsg_ini_subx_4 = lane[4];
    assign bus.APPmsg_ini_subx_5 = lane[5];
    assign bus.APPmsg_ini_subx_6 = lane[6];
    assign bus.APPmsg_ini_subx_7 = lane[7];

    // Reference: signed LLR per column/element and number of results since reset.
    int m_llr [NCOL][ZC];
    int m_frames;
    int b_llr [8][ZC];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [OUTW-1:0] obs, input logic [OUTW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OUTW-1:0] model_out();
        logic [OUTW-1:0] r;
        r = '0;
        for (int c = 0; c < DOL; c++)
            for (int z = 0; z < ZC; z++)
                r[c*ZC + z] = (m_llr[c][z] < 0);
        return r;
    endfunction

    function automatic logic [2:0] model_cnt();
`ifdef LDPC_DEC_FRAME_CNT_EN
        return 3'(m_frames % 8);
`else
        return 3'd0;
`endif
    endfunction

    task automatic fill_const(input int v);
        for (int k = 0; k < 8; k++)
            for (int z = 0; z < ZC; z++) b_llr[k][z] = v;
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 8; k++)
            for (int z = 0; z < ZC; z++) b_llr[k][z] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic put_lanes();
        for (int k = 0; k < 8; k++)
            for (int z = 0; z < ZC; z++) lane[k][z*VW +: VW] = VW'(b_llr[k][z]);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCOL; c++)
            for (int z = 0; z < ZC; z++) m_llr[c][z] = 0;
        m_frames = 0;
    endtask

    // One cycle of input; the model takes the beat if it is valid and not a 24-column group-3 beat.
    task automatic drive_beat(input logic [1:0] sx, input logic valid, input logic last, input logic start);
        put_lanes();
        bus.APPmsg_ini_sub_x = sx;
        bus.buffer_valid     = valid;
        bus.buffer_last      = last;
        bus.buffer_start     = start;
        @(posedge clk);
        if (valid && !(bus.iLs == 3'd2 && sx == 2'd3))
            for (int k = 0; k < 8; k++)
                for (int z = 0; z < ZC; z++) m_llr[int'(sx)*8 + k][z] = b_llr[k][z];
        #1;
        bus.buffer_valid = 1'b0;
        bus.buffer_last  = 1'b0;
        bus.buffer_start = 1'b0;
    endtask

    // Result must appear exactly n+2 edges after the buffer_last edge; hold drives junk beats meanwhile.
    task automatic wait_result(input int n, input bit hold, input string tag);
        bit bad;
        bad = 1'b0;
        for (int k = 1; k <= n + 2; k++) begin
            @(posedge clk); #1;
            if (k < n + 2) begin
                if (bus.decode_valid !== 1'b0 || bus.buffer_ready !== 1'b0) bad = 1'b1;
                if (hold) begin
                    fill_rand();
                    put_lanes();
                    bus.APPmsg_ini_sub_x = 2'($urandom_range(0, 3));
                    bus.buffer_valid     = 1'b1;
                    bus.buffer_last      = 1'($urandom_range(0, 1));
                    bus.buffer_start     = 1'($urandom_range(0, 1));
                end
            end
        end
        bus.buffer_valid = 1'b0;
        bus.buffer_last  = 1'b0;
        bus.buffer_start = 1'b0;
        check({tag, "_proc_quiet"}, OUTW'(bad), OUTW'(0));
        check({tag, "_valid"}, OUTW'(bus.decode_valid), OUTW'(1));
        check({tag, "_ready"}, OUTW'(bus.buffer_ready), OUTW'(1));
        check({tag, "_data"}, bus.APPmsg_decode_out, model_out());
        check({tag, "_cnt"}, OUTW'(bus.decode_valid_cnt), OUTW'(model_cnt()));
        m_frames++;
        @(posedge clk); #1;
        check({tag, "_single_pulse"}, OUTW'(bus.decode_valid), OUTW'(0));
    endtask

    initial begin
        logic [OUTW-1:0] ones;
        logic [OUTW-1:0] snap;
        logic [ZC-1:0]   alt;
        int n, nb;
        bit seen;

        ones = '1;
        alt  = {(ZC/2){2'b10}};
        model_reset();
        fill_const(0);
        put_lanes();
        bus.APPmsg_ini_sub_x = 2'd0;
        bus.buffer_valid     = 1'b0;
        bus.buffer_start     = 1'b0;
        bus.buffer_last      = 1'b0;
        bus.iLs              = 3'd1;
        bus.jLs              = 3'($urandom_range(0, 7));
        bus.P                = 6'($urandom_range(0, 63));
        bus.APP_addr_max     = 6'd16;
        bus.APP_addr_rd_max  = 5'($urandom_range(0, 31));

        #12;
        check("rst_ready", OUTW'(bus.buffer_ready), OUTW'(1));
        check("rst_valid", OUTW'(bus.decode_valid), OUTW'(0));
        check("rst_cnt",   OUTW'(bus.decode_valid_cnt), OUTW'(0));
        check("rst_data",  bus.APPmsg_decode_out, OUTW'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Full 32-column frame of all -1, last on beat 176.
        bus.iLs = 3'd1;
        bus.APP_addr_max = 6'd16;
        fill_const(-1);
        for (int g = 0; g < 3; g++)
            for (int b = 0; b < 16; b++) drive_beat(2'(g), 1'b1, 1'b0, (g == 0 && b == 0));
        for (int b = 0; b < 128; b++) drive_beat(2'd3, 1'b1, (b == 127), 1'b0);
        wait_result(16, 1'b0, "full");
        check("full_all_ones", bus.APPmsg_decode_out, ones);

        // Sign mapping: column 0 alternates +5/-5, column 21 zero, others +1.
        bus.APP_addr_max = 6'd5;
        for (int g = 0; g < 3; g++) begin
            fill_const(1);
            if (g == 0) for (int z = 0; z < ZC; z++) b_llr[0][z] = (z % 2 == 1) ? -5 : 5;
            if (g == 2) for (int z = 0; z < ZC; z++) b_llr[5][z] = 0;
            drive_beat(2'(g), 1'b1, (g == 2), (g == 0));
        end
        wait_result(5, 1'b0, "sign");
        snap = bus.APPmsg_decode_out;
        check("sign_col0", OUTW'(snap[ZC-1:0]), OUTW'(alt));
        check("sign_rest", OUTW'(snap[OUTW-1:ZC]), OUTW'(0));

        // 24-column mode: group 3 carries -1 and must be dropped.
        bus.iLs = 3'd2;
        bus.APP_addr_max = 6'd3;
        fill_const(1);
        for (int g = 0; g < 3; g++) drive_beat(2'(g), 1'b1, 1'b0, 1'b0);
        fill_const(-1);
        drive_beat(2'd3, 1'b1, 1'b0, 1'b0);
        drive_beat(2'd3, 1'b1, 1'b1, 1'b0);
        wait_result(3, 1'b0, "ils2");
        check("ils2_zero", bus.APPmsg_decode_out, OUTW'(0));

        // Overwrite: group 0 rewritten with +3 after -1; last with valid low ends the frame.
        bus.iLs = 3'd0;
        bus.APP_addr_max = 6'd0;
        fill_const(-1);  drive_beat(2'd0, 1'b1, 1'b0, 1'b1);
        fill_rand();     drive_beat(2'd1, 1'b1, 1'b0, 1'b0);
        fill_rand();     drive_beat(2'd2, 1'b1, 1'b0, 1'b0);
        fill_const(3);   drive_beat(2'd0, 1'b1, 1'b0, 1'b0);
        fill_rand();     drive_beat(2'd1, 1'b0, 1'b1, 1'b0);
        wait_result(0, 1'b0, "ovw");
        snap = bus.APPmsg_decode_out;
        check("ovw_cols0_7", OUTW'(snap[8*ZC-1:0]), OUTW'(0));

        // Nine randomized frames with junk beats held during processing.
        for (int f = 0; f < 9; f++) begin
            bus.iLs = 3'($urandom_range(0, 7));
            n = int'($urandom_range(0, 20));
            bus.APP_addr_max = 6'(n);
            nb = int'($urandom_range(1, 8));
            for (int b = 0; b < nb; b++) begin
                fill_rand();
                drive_beat(2'($urandom_range(0, 3)), 1'b1, (b == nb - 1), (b == 0));
            end
            wait_result(n, 1'b1, $sformatf("rnd%0d", f));
        end

        // Reset during processing aborts the frame and clears everything.
        bus.iLs = 3'd1;
        bus.APP_addr_max = 6'd12;
        fill_rand(); drive_beat(2'd1, 1'b1, 1'b0, 1'b1);
        fill_rand(); drive_beat(2'd0, 1'b1, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_ready", OUTW'(bus.buffer_ready), OUTW'(1));
        check("midrst_valid", OUTW'(bus.decode_valid), OUTW'(0));
        check("midrst_data",  bus.APPmsg_decode_out, OUTW'(0));
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (bus.decode_valid !== 1'b0) seen = 1'b1;
        end
        check("midrst_no_pulse", OUTW'(seen), OUTW'(0));

        // Single IDLE beat with last goes straight to processing; other columns read as cleared.
        bus.APP_addr_max = 6'd2;
        fill_rand();
        drive_beat(2'd0, 1'b1, 1'b1, 1'b1);
        wait_result(2, 1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
